// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - mem_op codes, FSM state type and store-lane helpers shared by mem_access
package mem_access_pkg;

  localparam int OP_W    = 4;
  localparam int STATE_W = 2;

  localparam logic [OP_W-1:0] OP_NOP = 4'd0;
  localparam logic [OP_W-1:0] OP_LB  = 4'd1;
  localparam logic [OP_W-1:0] OP_LBU = 4'd2;
  localparam logic [OP_W-1:0] OP_LH  = 4'd3;
  localparam logic [OP_W-1:0] OP_LHU = 4'd4;
  localparam logic [OP_W-1:0] OP_LW  = 4'd5;
  localparam logic [OP_W-1:0] OP_SB  = 4'd6;
  localparam logic [OP_W-1:0] OP_SH  = 4'd7;
  localparam logic [OP_W-1:0] OP_SW  = 4'd8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic is_store_op(input logic [OP_W-1:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic size_t op_size(input logic [OP_W-1:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      default:              return SZ_WORD;
    endcase
  endfunction

  // Half strobes ignore addr[0]: a misaligned half lands on its containing half-word.
  function automatic logic [3:0] store_strb(input logic [OP_W-1:0] op, input logic [1:0] lo);
    if (!is_store_op(op)) return 4'b0000;
    case (op_size(op))
      SZ_BYTE: return 4'b0001 << lo;
      SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [OP_W-1:0] op, input logic [31:0] data);
    if (!is_store_op(op)) return 32'h0;
    case (op_size(op))
      SZ_BYTE: return {4{data[7:0]}};
      SZ_HALF: return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [OP_W-1:0] op, input logic [1:0] lo);
    case (op_size(op))
      SZ_HALF: return lo[0];
      SZ_WORD: return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// rtl/mem_access_load_align.sv - selects the addressed byte/half of a load response and extends it
module load_align
  import mem_access_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [1:0]      addr_lo,
  input  logic [31:0]     rdata,
  output logic [31:0]     data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    data     = rdata;
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    case (op)
      OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data = {24'h0, byte_sel};
      OP_LH:   data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM-stage data-bus access FSM with registered writeback and upstream stall
// Optional MISALIGN_CHECK_EN: rejects misaligned half/word accesses and pulses misalign_exc.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic [OP_W-1:0]   mem_op,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_store_data,
  input  logic [31:0]       mem_reg_write_data,
  input  logic [4:0]        mem_reg_write_addr,
  input  logic              mem_reg_write_en,
  output logic              data_req,
  output logic              data_we,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic [31:0]       wb_reg_write_data,
  output logic [4:0]        wb_reg_write_addr,
  output logic              wb_reg_write_en,
  output logic              stall_req
`ifdef MISALIGN_CHECK_EN
  ,
  output logic              misalign_exc
`endif
);

  state_t          state;
  logic [OP_W-1:0] op_q;
  logic [4:0]      rd_addr_q;
  logic            rd_en_q;
  logic            mem_cmd;
  logic            misaligned;
  logic            start;
  logic            complete;
  logic [31:0]     load_data;

  assign mem_cmd = mem_valid && is_mem_op(mem_op);

`ifdef MISALIGN_CHECK_EN
  assign misaligned   = is_misaligned(mem_op, mem_addr[1:0]);
  assign misalign_exc = (state == ST_IDLE) && mem_cmd && misaligned;
`else
  assign misaligned   = 1'b0;
`endif

  assign start    = (state == ST_IDLE) && mem_cmd && !misaligned;
  assign complete = ((state == ST_ADDR) && data_addr_ok && data_data_ok) ||
                    ((state == ST_DATA) && data_data_ok);
  // The completion cycle already releases the pipeline so the next op lands in IDLE.
  assign stall_req = start || ((state != ST_IDLE) && !complete);

  load_align u_load_align (
    .op      (op_q),
    .addr_lo (data_addr[1:0]),
    .rdata   (data_rdata),
    .data    (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= ST_IDLE;
      data_req          <= 1'b0;
      data_we           <= 1'b0;
      data_addr         <= '0;
      data_wstrb        <= 4'b0000;
      data_wdata        <= 32'h0;
      op_q              <= OP_NOP;
      rd_addr_q         <= 5'd0;
      rd_en_q           <= 1'b0;
      wb_reg_write_data <= 32'h0;
      wb_reg_write_addr <= 5'd0;
      wb_reg_write_en   <= 1'b0;
    end else begin
      wb_reg_write_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_ADDR;
            data_req   <= 1'b1;
            data_we    <= is_store_op(mem_op);
            data_addr  <= mem_addr;
            data_wstrb <= store_strb(mem_op, mem_addr[1:0]);
            data_wdata <= store_lanes(mem_op, mem_store_data);
            op_q       <= mem_op;
            rd_addr_q  <= mem_reg_write_addr;
            rd_en_q    <= mem_reg_write_en && !is_store_op(mem_op);
          end else if (!mem_cmd) begin
            // A rejected misaligned access falls through neither branch: one-cycle bubble.
            wb_reg_write_data <= mem_reg_write_data;
            wb_reg_write_addr <= mem_reg_write_addr;
            wb_reg_write_en   <= mem_reg_write_en;
          end
        end
        ST_ADDR: begin
          if (data_addr_ok) begin
            data_req <= 1'b0;
            state    <= data_data_ok ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (data_data_ok) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (complete) begin
        wb_reg_write_data <= load_data;
        wb_reg_write_addr <= rd_addr_q;
        wb_reg_write_en   <= rd_en_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - randomized bench for mem_access against a transaction-level reference
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_valid = 1'b0;
  logic [3:0]  mem_op = 4'd0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_store_data = 32'h0;
  logic [31:0] mem_reg_write_data = 32'h0;
  logic [4:0]  mem_reg_write_addr = 5'd0;
  logic        mem_reg_write_en = 1'b0;
  logic        data_req, data_we;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok = 1'b0;
  logic        data_data_ok = 1'b0;
  logic [31:0] data_rdata = 32'h0;
  logic [31:0] wb_reg_write_data;
  logic [4:0]  wb_reg_write_addr;
  logic        wb_reg_write_en;
  logic        stall_req;
`ifdef MISALIGN_CHECK_EN
  logic        misalign_exc;
`endif

  mem_access #(.ADDR_W(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .mem_valid          (mem_valid),
    .mem_op             (mem_op),
    .mem_addr           (mem_addr),
    .mem_store_data     (mem_store_data),
    .mem_reg_write_data (mem_reg_write_data),
    .mem_reg_write_addr (mem_reg_write_addr),
    .mem_reg_write_en   (mem_reg_write_en),
    .data_req           (data_req),
    .data_we            (data_we),
    .data_addr          (data_addr),
    .data_wstrb         (data_wstrb),
    .data_wdata         (data_wdata),
    .data_addr_ok       (data_addr_ok),
    .data_data_ok       (data_data_ok),
    .data_rdata         (data_rdata),
    .wb_reg_write_data  (wb_reg_write_data),
    .wb_reg_write_addr  (wb_reg_write_addr),
    .wb_reg_write_en    (wb_reg_write_en),
    .stall_req          (stall_req)
`ifdef MISALIGN_CHECK_EN
    ,
    .misalign_exc       (misalign_exc)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int stall_cnt = 0;

  logic        chk_on = 1'b0;
  logic        exp_stall = 1'b0, exp_req = 1'b0, exp_mis = 1'b0;
  logic        e_we = 1'b0;
  logic [31:0] e_addr = 32'h0, e_wdata = 32'h0;
  logic [3:0]  e_strb = 4'h0;
  logic        exp_wb_en = 1'b0, exp_wb_dchk = 1'b0;
  logic [31:0] exp_wb_data = 32'h0;
  logic [4:0]  exp_wb_addr = 5'd0;
  logic        nxt_en = 1'b0, nxt_dchk = 1'b0;
  logic [31:0] nxt_data = 32'h0;
  logic [4:0]  nxt_addr = 5'd0;
  logic        lit_wb = 1'b0, lit_wb_en = 1'b0, lit_st = 1'b0, lit_stall = 1'b0, cnt_clr = 1'b0;
  logic [31:0] lit_wb_data = 32'h0, lit_wdata = 32'h0;
  logic [4:0]  lit_wb_addr = 5'd0;
  logic [3:0]  lit_strb = 4'h0;
  int          lit_stall_n = 0;

  // ---- reference rules: sizes in bytes, lanes chosen by size-aligned base ----
  function automatic bit m_store(input logic [3:0] op);
    return op == OP_SB || op == OP_SH || op == OP_SW;
  endfunction

  function automatic int m_bytes(input logic [3:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_strb(input logic [3:0] op, input logic [1:0] lo);
    int n;
    int base;
    n = m_bytes(op);
    base = (int'(lo) / n) * n;
    return 4'(((1 << n) - 1) << base);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] sd);
    logic [31:0] w;
    int n;
    n = m_bytes(op);
    for (int k = 0; k < 4; k++) w[8*k +: 8] = sd[8*(k % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [1:0] lo, input logic [31:0] rd);
    int n;
    int base;
    logic [31:0] mask;
    logic [31:0] v;
    n = m_bytes(op);
    base = (int'(lo) / n) * n;
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 32'd1);
    v = (rd >> (8*base)) & mask;
    if ((op == OP_LB || op == OP_LH) && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // ---- compare process ----
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    stall_cnt = (cnt_clr ? 0 : stall_cnt) + int'(stall_req);
    if (chk_on) begin
      cmp("stall_req", 32'(stall_req), 32'(exp_stall));
      cmp("data_req", 32'(data_req), 32'(exp_req));
      if (exp_req) begin
        cmp("data_addr", data_addr, e_addr);
        cmp("data_we", 32'(data_we), 32'(e_we));
        if (e_we) begin
          cmp("data_wstrb", 32'(data_wstrb), 32'(e_strb));
          cmp("data_wdata", data_wdata, e_wdata);
        end
      end
      cmp("wb_en", 32'(wb_reg_write_en), 32'(exp_wb_en));
      if (exp_wb_dchk) begin
        cmp("wb_data", wb_reg_write_data, exp_wb_data);
        cmp("wb_addr", 32'(wb_reg_write_addr), 32'(exp_wb_addr));
      end
`ifdef MISALIGN_CHECK_EN
      cmp("misalign_exc", 32'(misalign_exc), 32'(exp_mis));
`endif
    end
    if (lit_wb) begin
      cmp("lit_wb_en", 32'(wb_reg_write_en), 32'(lit_wb_en));
      if (lit_wb_en) begin
        cmp("lit_wb_data", wb_reg_write_data, lit_wb_data);
        cmp("lit_wb_addr", 32'(wb_reg_write_addr), 32'(lit_wb_addr));
      end
    end
    if (lit_st && exp_req) begin
      cmp("lit_wstrb", 32'(data_wstrb), 32'(lit_strb));
      cmp("lit_wdata", data_wdata, lit_wdata);
      cmp("lit_we", 32'(data_we), 32'd1);
    end
    if (lit_stall) cmp("lit_stall_cycles", 32'(stall_cnt), 32'(lit_stall_n));
  end

  // ---- stimulus ----
  task automatic tick();
    @(posedge clk);
    #1;
    exp_wb_en   = nxt_en;
    exp_wb_dchk = nxt_dchk;
    exp_wb_data = nxt_data;
    exp_wb_addr = nxt_addr;
    nxt_en    = 1'b0;
    nxt_dchk  = 1'b0;
    lit_wb    = 1'b0;
    lit_stall = 1'b0;
    cnt_clr   = 1'b0;
  endtask

  task automatic alu_cycle(input bit valid, input logic [3:0] op, input logic [31:0] d,
                           input logic [4:0] a, input bit en);
    mem_valid = valid;
    mem_op = op;
    mem_addr = $urandom;
    mem_store_data = $urandom;
    mem_reg_write_data = d;
    mem_reg_write_addr = a;
    mem_reg_write_en = en;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata = $urandom;
    exp_stall = 1'b0;
    exp_req = 1'b0;
    exp_mis = 1'b0;
    nxt_en = en;
    nxt_dchk = 1'b1;
    nxt_data = d;
    nxt_addr = a;
    tick();
  endtask

  task automatic mem_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [4:0] rd, input bit en, input int a_lat, input int d_lat,
                         input logic [31:0] rdata);
    mem_valid = 1'b1;
    mem_op = op;
    mem_addr = addr;
    mem_store_data = sd;
    mem_reg_write_data = $urandom;
    mem_reg_write_addr = rd;
    mem_reg_write_en = en;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    exp_stall = 1'b1;
    exp_req = 1'b0;
    exp_mis = 1'b0;
    e_addr = addr;
    e_we = m_store(op);
    e_strb = m_strb(op, addr[1:0]);
    e_wdata = m_wdata(op, sd);
    tick();
    for (int i = 0; i <= a_lat; i++) begin
      exp_req = 1'b1;
      data_addr_ok = (i == a_lat);
      data_data_ok = (i == a_lat) && (d_lat == 0);
      data_rdata = data_data_ok ? rdata : $urandom;
      exp_stall = !data_data_ok;
      if (data_data_ok) begin
        nxt_en = !m_store(op) && en;
        nxt_dchk = nxt_en;
        nxt_data = m_load(op, addr[1:0], rdata);
        nxt_addr = rd;
      end
      tick();
    end
    for (int j = 1; j <= d_lat; j++) begin
      exp_req = 1'b0;
      data_addr_ok = 1'b0;
      data_data_ok = (j == d_lat);
      data_rdata = data_data_ok ? rdata : $urandom;
      exp_stall = !data_data_ok;
      if (data_data_ok) begin
        nxt_en = !m_store(op) && en;
        nxt_dchk = nxt_en;
        nxt_data = m_load(op, addr[1:0], rdata);
        nxt_addr = rd;
      end
      tick();
    end
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] addr;
    int          kind;

    // reset state
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_on = 1'b1;
    exp_stall = 1'b0;
    exp_req = 1'b0;
    exp_wb_en = 1'b0;
    exp_wb_dchk = 1'b1;
    exp_wb_data = 32'h0;
    exp_wb_addr = 5'd0;
    nxt_dchk = 1'b1;
    tick();
    rst = 1'b1;

    // ALU op passes straight through
    alu_cycle(1'b1, 4'd9, 32'h1234, 5'd3, 1'b1);
    lit_wb = 1'b1; lit_wb_en = 1'b1; lit_wb_data = 32'h1234; lit_wb_addr = 5'd3;
    alu_cycle(1'b0, OP_NOP, 32'h0, 5'd0, 1'b0);

    // LB with addr_ok one cycle late and data_ok two cycles after that
    cnt_clr = 1'b1;
    mem_txn(OP_LB, 32'h1001, 32'h0, 5'd7, 1'b1, 1, 2, 32'h0000_8000);
    lit_wb = 1'b1; lit_wb_en = 1'b1; lit_wb_data = 32'hFFFF_FF80; lit_wb_addr = 5'd7;
    lit_stall = 1'b1; lit_stall_n = 4;
    alu_cycle(1'b0, OP_NOP, 32'h0, 5'd0, 1'b0);

    // SH upper half
    lit_st = 1'b1; lit_strb = 4'b1100; lit_wdata = 32'hABCD_ABCD;
    mem_txn(OP_SH, 32'h2002, 32'h0000_ABCD, 5'd9, 1'b1, 0, 1, 32'h5555_5555);
    lit_st = 1'b0;
    lit_wb = 1'b1; lit_wb_en = 1'b0;
    alu_cycle(1'b0, OP_NOP, 32'h0, 5'd0, 1'b0);

    // LW with addr_ok and data_ok together
    mem_txn(OP_LW, 32'h0000_0040, 32'h0, 5'd12, 1'b1, 0, 0, 32'hDEAD_BEEF);
    lit_wb = 1'b1; lit_wb_en = 1'b1; lit_wb_data = 32'hDEAD_BEEF; lit_wb_addr = 5'd12;
    alu_cycle(1'b0, OP_NOP, 32'h0, 5'd0, 1'b0);

    // reset while waiting for data, stray data_ok afterwards
    mem_valid = 1'b1; mem_op = OP_LW; mem_addr = 32'h0000_0100; mem_reg_write_addr = 5'd4;
    mem_reg_write_en = 1'b1; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    exp_stall = 1'b1; exp_req = 1'b0;
    e_addr = 32'h0000_0100; e_we = 1'b0;
    tick();
    exp_req = 1'b1; data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; exp_req = 1'b0; exp_stall = 1'b1; rst = 1'b0;
    nxt_en = 1'b0; nxt_dchk = 1'b1; nxt_data = 32'h0; nxt_addr = 5'd0;
    tick();
    rst = 1'b1; mem_valid = 1'b0; mem_reg_write_en = 1'b0; mem_reg_write_data = 32'h77;
    mem_reg_write_addr = 5'd2; data_data_ok = 1'b1; data_rdata = 32'h1111_2222;
    exp_stall = 1'b0; exp_req = 1'b0;
    nxt_en = 1'b0; nxt_dchk = 1'b1; nxt_data = 32'h77; nxt_addr = 5'd2;
    tick();
    lit_wb = 1'b1; lit_wb_en = 1'b0;
    alu_cycle(1'b0, OP_NOP, 32'h0, 5'd0, 1'b0);

`ifdef MISALIGN_CHECK_EN
    mem_valid = 1'b1; mem_op = OP_LW; mem_addr = 32'h3002; mem_reg_write_en = 1'b1;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    exp_stall = 1'b0; exp_req = 1'b0; exp_mis = 1'b1;
    tick();
    lit_wb = 1'b1; lit_wb_en = 1'b0;
    alu_cycle(1'b0, OP_NOP, 32'h0, 5'd0, 1'b0);
`endif

    // randomized mix
    for (int t = 0; t < 250; t++) begin
      kind = $urandom_range(0, 9);
      if (kind < 3) begin
        op = ($urandom_range(0, 7) == 0) ? OP_NOP : 4'($urandom_range(9, 15));
        alu_cycle(1'b1, op, $urandom, 5'($urandom), 1'($urandom));
      end else if (kind == 3) begin
        alu_cycle(1'b0, 4'($urandom), $urandom, 5'($urandom), 1'($urandom));
      end else begin
        op = 4'($urandom_range(1, 8));
        addr = $urandom;
`ifdef MISALIGN_CHECK_EN
        addr = addr & ~(32'(m_bytes(op)) - 32'd1);
`endif
        mem_txn(op, addr, $urandom, 5'($urandom), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      end
    end
    alu_cycle(1'b0, OP_NOP, 32'h0, 5'd0, 1'b0);
    alu_cycle(1'b0, OP_NOP, 32'h0, 5'd0, 1'b0);
    chk_on = 1'b0;
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter: ADDR_W, default 32, data-bus address width.
REQ-002 Port: clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 Port: rst  in  1  synchronous, active-low reset.
REQ-004 Ports: mem_valid in 1, mem_op in 4, mem_addr in ADDR_W, mem_store_data in 32  instruction in MEM stage, op code, effective address, store operand.
REQ-005 Ports: mem_reg_write_data in 32, mem_reg_write_addr in 5, mem_reg_write_en in 1  register-write fields arriving from the EX/MEM pipeline register.
REQ-006 Ports: data_req out 1, data_we out 1, data_addr out ADDR_W, data_wstrb out 4, data_wdata out 32  data-bus request channel.
REQ-007 Ports: data_addr_ok in 1, data_data_ok in 1, data_rdata in 32  data-bus acceptance and response.
REQ-008 Ports: wb_reg_write_data out 32, wb_reg_write_addr out 5, wb_reg_write_en out 1  registered writeback fields.
REQ-009 Port: stall_req out 1  combinational; freezes upstream stages while an access is outstanding.

Function
REQ-010 The FSM SHALL have states IDLE, ADDR, DATA.
- IDLE -> ADDR when mem_valid and mem_op is a load or store.
- ADDR -> DATA on data_addr_ok.
- ADDR -> IDLE when data_addr_ok and data_data_ok are both high in the same cycle.
- DATA -> IDLE on data_data_ok.
REQ-011 data_req SHALL be high only in ADDR; data_addr, data_we, data_wstrb and data_wdata SHALL hold stable until data_addr_ok.
REQ-012 Non-memory ops and mem_valid=0 SHALL pass the mem_reg_write_* fields to wb_* with 1-cycle latency and stall_req=0.
REQ-013 stall_req SHALL be high in IDLE when a memory op is presented, in ADDR, and in DATA until data_data_ok (inclusive of the request cycle, exclusive of the completion cycle).
REQ-014 Store strobes SHALL follow the op size:
- byte: one-hot on addr[1:0];
- half: 4'b0011 or 4'b1100 per addr[1];
- word: 4'b1111.
- data_wdata SHALL replicate the byte or half across all lanes.
REQ-015 Loads SHALL extract the addressed byte or half from data_rdata and sign- or zero-extend it per op; the result SHALL be registered to wb_reg_write_data in the cycle after data_data_ok.
REQ-016 For a store, wb_reg_write_en SHALL be 0 on completion.
REQ-017 While stalled, wb_reg_write_en SHALL be 0, inserting a bubble.
REQ-018 data_addr SHALL present mem_addr unchanged; alignment is handled by the strobes only.

Reset
REQ-019 With rst=0 at a clock edge:
- FSM SHALL enter IDLE;
- all wb_* outputs SHALL be 0;
- data_req SHALL be 0.
REQ-020 Reset in ADDR or DATA SHALL abandon the transaction; a data_data_ok arriving after reset release while in IDLE SHALL be ignored.

Configuration
REQ-021 Macro MISALIGN_CHECK_EN defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL suppress data_req, complete in 1 cycle with wb_reg_write_en=0, and pulse output misalign_exc (1 bit) for that cycle.
REQ-022 Macro MISALIGN_CHECK_EN undefined: no misalign_exc port; misaligned accesses SHALL be issued using the truncated strobe/extract rules of REQ-014/015.

Structure
REQ-023 mem_op encodings (LB, LBU, LH, LHU, LW, SB, SH, SW, NOP), FSM state codes and widths SHALL live in the shared define file.
REQ-024 Load byte/half selection and extension SHALL be a combinational sub-module named load_align.

Verification
REQ-025 ALU op, mem_reg_write_data=0x1234, addr=3, en=1 -> next cycle wb_* = 0x1234/3/1, stall_req never high.
REQ-026 LB addr=0x1001, rdata=0x0000_8000, addr_ok one cycle after req, data_ok two cycles later -> wb_reg_write_data=0xFFFF_FF80; stall_req high exactly 4 cycles.
REQ-027 SH addr=0x2002, store_data=0xABCD -> wstrb=4'b1100, wdata=0xABCD_ABCD, data_we=1, wb_reg_write_en=0.
REQ-028 LW with addr_ok and data_ok in the same cycle, rdata=0xDEADBEEF -> FSM ADDR->IDLE, wb data 0xDEADBEEF next cycle.
REQ-029 rst=0 asserted in DATA, then data_data_ok pulsed after release -> no wb write, FSM stays IDLE.
REQ-030 MISALIGN_CHECK_EN defined, LW addr=0x3002 -> data_req never high, misalign_exc=1 for 1 cycle, wb_reg_write_en=0.
